// File: rtl/rr_core_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_core_arbiter_pkg
//   Shared definitions for the core round-robin arbiter: default core count,
//   core index width, default lock length and the arbiter state encoding.
// -----------------------------------------------------------------------------
package rr_core_arbiter_pkg;

    localparam int NUM_OF_CORES = 4;   // default number of requesters
    localparam int CORE_ID_SIZE = 2;   // default requester index width
    localparam int ARB_MAX_HOLD = 8;   // default max accepted beats per lock
    localparam int HOLD_CNT_W   = 8;   // holds MAX_HOLD-1 for MAX_HOLD <= 255

    typedef enum logic [1:0] {
        ARB_STATE_IDLE  = 2'd0,
        ARB_STATE_GRANT = 2'd1,
        ARB_STATE_HOLD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_core_arbiter_find_next.sv
// -----------------------------------------------------------------------------
// rr_find_next
//   Circular priority search. Scans mask starting at start+1, wrapping modulo
//   NUM_REQ (also for non-power-of-2 counts), ending at start itself, and
//   returns the first set index.
//   Ports:
//     mask    in  NUM_REQ  candidate requesters
//     start   in  ID_W     last served index; search begins just after it
//     next_id out ID_W     first set index found (0 when none)
//     none    out 1        mask is all zero
// -----------------------------------------------------------------------------
module rr_find_next #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    next_id,
    output logic               none
);

    // Walk from the farthest candidate back to the nearest so the nearest
    // set bit after start is the one left in next_id.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves a combinational output unassigned would infer a latch.
        next_id = '0;
        none    = 1'b1;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(start) + k) % NUM_REQ;
            if (mask[idx]) begin
                next_id = ID_W'(idx);
                none    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rr_core_arbiter.sv
// -----------------------------------------------------------------------------
// rr_core_arbiter
//   Registered round-robin (or fixed-priority) arbiter with valid/ready grant
//   handshake and bounded multi-beat lock. All outputs come from registers.
//   Ports:
//     clk          in  1        rising-edge clock
//     reset        in  1        synchronous, active-low reset
//     req          in  NUM_REQ  request vector
//     grant_ready  in  1        consumer accepts one beat of the grant
//     lock         in  1        with grant_ready: keep grant for another beat
//     grant_valid  out 1        grant offered
//     grant_id     out ID_W     granted index
//     grant_onehot out NUM_REQ  one-hot of grant_id, zero when not valid
//     ptr_id       out ID_W     last served index
//     no_req       out 1        (req == 0) registered
// -----------------------------------------------------------------------------
module rr_core_arbiter
    import rr_core_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_OF_CORES,
    parameter int ID_W      = CORE_ID_SIZE,
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = ARB_MAX_HOLD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_ready,
    input  logic               lock,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    ptr_id,
    output logic               no_req
);

    localparam logic [ID_W-1:0]       LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

    arb_state_e            state, state_d;
    logic [ID_W-1:0]       grant_id_d, ptr_d, search_start, win_id;
    logic                  grant_valid_d, win_none, release_grant;
    logic [HOLD_CNT_W-1:0] hold_cnt, hold_d;

    // A single search serves both cases: from the pointer when idle, and
    // from the current grant when it is being released. Fixed priority
    // always searches from the top index so index 0 wins.
    always_comb begin
        if (PRIO_MODE != 0)              search_start = LAST_ID;
        else if (state == ARB_STATE_IDLE) search_start = ptr_id;
        else                              search_start = grant_id;
    end

    rr_find_next #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_find_next (
        .mask    (req),
        .start   (search_start),
        .next_id (win_id),
        .none    (win_none)
    );

    always_comb begin
        state_d       = state;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        ptr_d         = ptr_id;
        hold_d        = hold_cnt;
        release_grant = 1'b0;

        unique case (state)
            ARB_STATE_IDLE: begin
                if (req != '0) begin
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                    state_d       = ARB_STATE_GRANT;
                end
            end
            ARB_STATE_GRANT: begin
                // Accept takes precedence over a request dropped in the same cycle.
                if (grant_ready) begin
                    if (lock && (MAX_HOLD > 1)) begin
                        hold_d  = HOLD_CNT_W'(1);
                        state_d = ARB_STATE_HOLD;
                    end else begin
                        release_grant = 1'b1;
                    end
                end else if (!req[grant_id]) begin
                    grant_valid_d = 1'b0;
                    state_d       = ARB_STATE_IDLE;
                end
            end
            ARB_STATE_HOLD: begin
                if (grant_ready) begin
                    if (lock && (hold_cnt < HOLD_LAST)) hold_d = hold_cnt + HOLD_CNT_W'(1);
                    else                                release_grant = 1'b1;
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = ARB_STATE_IDLE;
            end
        endcase

        // Final beat: advance the pointer and hand over without a bubble.
        if (release_grant) begin
            if (PRIO_MODE == 0) ptr_d = grant_id;
            hold_d = '0;
            if (!win_none) begin
                grant_id_d    = win_id;
                grant_valid_d = 1'b1;
                state_d       = ARB_STATE_GRANT;
            end else begin
                grant_valid_d = 1'b0;
                state_d       = ARB_STATE_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!reset) begin
            state       <= ARB_STATE_IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr_id      <= LAST_ID;
            hold_cnt    <= '0;
            no_req      <= 1'b1;
        end else begin
            state       <= state_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
            ptr_id      <= ptr_d;
            hold_cnt    <= hold_d;
            no_req      <= (req == '0);
        end
    end

    // Decoded from registers only, so it cannot glitch on input changes.
    always_comb begin
        grant_onehot = '0;
        if (grant_valid) grant_onehot[grant_id] = 1'b1;
    end

endmodule

// File: tb/tb_rr_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_core_arbiter
//   Directed bench for rr_core_arbiter. Three instances share clock and reset:
//     a: NUM_REQ=4, round-robin, MAX_HOLD=3
//     b: NUM_REQ=5, round-robin (non-power-of-2 wrap)
//     c: NUM_REQ=4, fixed priority
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_rr_core_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // instance a
    logic [3:0] a_req;
    logic       a_ready, a_lock, a_gv, a_noreq;
    logic [1:0] a_gid, a_ptr;
    logic [3:0] a_oh;
    // instance b
    logic [4:0] b_req;
    logic       b_ready, b_lock, b_gv, b_noreq;
    logic [2:0] b_gid, b_ptr;
    logic [4:0] b_oh;
    // instance c
    logic [3:0] c_req;
    logic       c_ready, c_lock, c_gv, c_noreq;
    logic [1:0] c_gid, c_ptr;
    logic [3:0] c_oh;

    rr_core_arbiter #(.NUM_REQ(4), .ID_W(2), .PRIO_MODE(0), .MAX_HOLD(3)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .grant_ready(a_ready), .lock(a_lock),
        .grant_valid(a_gv), .grant_id(a_gid), .grant_onehot(a_oh), .ptr_id(a_ptr),
        .no_req(a_noreq));

    rr_core_arbiter #(.NUM_REQ(5), .ID_W(3), .PRIO_MODE(0), .MAX_HOLD(8)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .grant_ready(b_ready), .lock(b_lock),
        .grant_valid(b_gv), .grant_id(b_gid), .grant_onehot(b_oh), .ptr_id(b_ptr),
        .no_req(b_noreq));

    rr_core_arbiter #(.NUM_REQ(4), .ID_W(2), .PRIO_MODE(1), .MAX_HOLD(8)) dut_c (
        .clk(clk), .reset(reset), .req(c_req), .grant_ready(c_ready), .lock(c_lock),
        .grant_valid(c_gv), .grant_id(c_gid), .grant_onehot(c_oh), .ptr_id(c_ptr),
        .no_req(c_noreq));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_req = '0; a_ready = 1'b0; a_lock = 1'b0;
        b_req = '0; b_ready = 1'b0; b_lock = 1'b0;
        c_req = '0; c_ready = 1'b0; c_lock = 1'b0;
        tick(); tick();

        // ---- reset state ----
        check("rst_a_gv",    32'(a_gv),    32'h0);
        check("rst_a_ptr",   32'(a_ptr),   32'h3);
        check("rst_a_noreq", 32'(a_noreq), 32'h1);
        check("rst_b_ptr",   32'(b_ptr),   32'h4);

        reset = 1'b1;
        repeat (5) tick();
        check("idle_a_gv",    32'(a_gv),    32'h0);
        check("idle_a_ptr",   32'(a_ptr),   32'h3);
        check("idle_a_noreq", 32'(a_noreq), 32'h1);
        check("idle_a_oh",    32'(a_oh),    32'h0);

        // ---- round-robin fairness, all requesting ----
        a_req = 4'b1111; a_ready = 1'b1;
        #2;
        check("rr_latency_gv", 32'(a_gv), 32'h0);
        tick();
        check("rr_g0",     32'(a_gid),   32'h0);
        check("rr_g0_gv",  32'(a_gv),    32'h1);
        check("rr_g0_oh",  32'(a_oh),    32'h1);
        check("rr_noreq",  32'(a_noreq), 32'h0);
        tick();
        check("rr_g1",     32'(a_gid),   32'h1);
        check("rr_g1_ptr", 32'(a_ptr),   32'h0);
        tick();
        check("rr_g2",     32'(a_gid),   32'h2);
        check("rr_g2_gv",  32'(a_gv),    32'h1);
        tick();
        check("rr_g3",     32'(a_gid),   32'h3);
        check("rr_g3_oh",  32'(a_oh),    32'h8);
        tick();
        check("rr_g0b",     32'(a_gid),  32'h0);
        check("rr_g0b_ptr", 32'(a_ptr),  32'h3);

        // ---- sparse mask with wrap from ptr 2 ----
        tick();                         // grant 1, ptr 0
        tick();                         // grant 2, ptr 1
        check("sp_g2", 32'(a_gid), 32'h2);
        a_req = 4'b0011;
        tick();
        check("sp_wrap_g0",  32'(a_gid), 32'h0);
        check("sp_wrap_ptr", 32'(a_ptr), 32'h2);
        tick();
        check("sp_g1",     32'(a_gid), 32'h1);
        check("sp_g1_ptr", 32'(a_ptr), 32'h0);
        a_req = 4'b0000;
        tick();
        check("sp_idle_gv",  32'(a_gv),  32'h0);
        check("sp_idle_ptr", 32'(a_ptr), 32'h1);

        // ---- lock for MAX_HOLD=3 beats ----
        a_req = 4'b0010; a_ready = 1'b0;
        tick();
        check("lk_g1", 32'(a_gid), 32'h1);
        a_req = 4'b1111; a_ready = 1'b1; a_lock = 1'b1;
        tick();
        check("lk_beat1", 32'(a_gid), 32'h1);
        tick();
        check("lk_beat2", 32'(a_gid), 32'h1);
        check("lk_beat2_gv", 32'(a_gv), 32'h1);
        tick();
        check("lk_next_g2",  32'(a_gid), 32'h2);
        check("lk_next_ptr", 32'(a_ptr), 32'h1);

        // ---- revoke ----
        a_ready = 1'b0; a_lock = 1'b0; a_req = 4'b1011;
        tick();
        check("rv_gv",  32'(a_gv),  32'h0);
        check("rv_ptr", 32'(a_ptr), 32'h1);
        check("rv_oh",  32'(a_oh),  32'h0);
        tick();
        check("rv_regrant_g3", 32'(a_gid), 32'h3);

        // ---- accept beats a same-cycle request drop ----
        a_ready = 1'b1; a_req = 4'b0111;
        tick();
        check("acc_drop_g0",  32'(a_gid), 32'h0);
        check("acc_drop_ptr", 32'(a_ptr), 32'h3);

        // ---- reset during a locked burst ----
        a_req = 4'b1111; a_lock = 1'b1;
        tick();                         // beat 1 accepted, now holding
        check("mh_hold_g0", 32'(a_gid), 32'h0);
        reset = 1'b0;
        tick();
        check("mh_rst_gv",    32'(a_gv),    32'h0);
        check("mh_rst_gid",   32'(a_gid),   32'h0);
        check("mh_rst_oh",    32'(a_oh),    32'h0);
        check("mh_rst_ptr",   32'(a_ptr),   32'h3);
        check("mh_rst_noreq", 32'(a_noreq), 32'h1);
        reset = 1'b1; a_req = 4'b1100; a_ready = 1'b0; a_lock = 1'b0;
        tick();
        check("mh_after_g2", 32'(a_gid), 32'h2);
        check("mh_after_gv", 32'(a_gv),  32'h1);
        a_req = 4'b0000;

        // ---- NUM_REQ=5 wrap 4 -> 0 ----
        b_req = 5'b10001; b_ready = 1'b1;
        tick();
        check("b_g0", 32'(b_gid), 32'h0);
        tick();
        check("b_g4",     32'(b_gid), 32'h4);
        check("b_g4_ptr", 32'(b_ptr), 32'h0);
        check("b_g4_oh",  32'(b_oh),  32'h10);
        tick();
        check("b_wrap_g0",  32'(b_gid), 32'h0);
        check("b_wrap_ptr", 32'(b_ptr), 32'h4);
        b_req = '0;

        // ---- fixed priority ----
        c_req = 4'b0110; c_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("prio_g1_%0d", i), 32'(c_gid), 32'h1);
        end
        check("prio_ptr", 32'(c_ptr), 32'h3);
        check("prio_gv",  32'(c_gv),  32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
